i2c_cmd_sequencer: RTL and testbench

- Transaction sequencer that sits directly upstream of the I2C master and queues host commands for it.
- Buffers {addr, rw, data} commands in a FIFO and launches them one at a time on the master's start/addr/rw/data_w interface.
- Tracks busy to detect completion, captures read data (data_out on valid_out) and address-NACK (erro_addr), and returns one response per command over a valid/ready port.
- Adds watchdog timeouts so a stuck bus cannot hang the host.

---
 rtl/i2c_seq_pkg.sv | 10 +
 rtl/i2c_cmd_fifo.sv | 36 +++
 rtl/i2c_cmd_sequencer.sv | 114 +++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared command, state and response-code types for the I2C command sequencer
package i2c_seq_pkg;
   typedef struct packed {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] data;
   } i2c_cmd_t;
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} seq_state_e;
   typedef enum logic [1:0] {ERR_OK, ERR_NACK, ERR_START_TO, ERR_TXN_TO} rsp_err_e;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous FIFO of I2C commands with registered occupancy
module i2c_cmd_fifo import i2c_seq_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  i2c_cmd_t                 din,
   input  logic                     pop,
   output i2c_cmd_t                 dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   i2c_cmd_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (do_push) mem[wr_ptr] <= din;
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host commands and runs them one at a time on an I2C master with watchdogs
module i2c_cmd_sequencer import i2c_seq_pkg::*; #(
   parameter int DEPTH    = 4,
   parameter int START_TO = 16,
   parameter int TXN_TO   = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [6:0]             cmd_addr,
   input  logic                   cmd_rw,
   input  logic [7:0]             cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [7:0]             rsp_rdata,
   output logic                   rsp_rw,
   output logic [1:0]             rsp_err,
   output logic                   m_start,
   output logic [6:0]             m_addr,
   output logic                   m_rw,
   output logic [7:0]             m_data_w,
   input  logic                   m_busy,
   input  logic                   m_valid_out,
   input  logic [7:0]             m_data_out,
   input  logic                   m_erro_addr,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int WD_MAX = START_TO > TXN_TO ? START_TO : TXN_TO;
   localparam int WD_W = $clog2(WD_MAX + 1);
   seq_state_e state, state_n;
   rsp_err_e err_n;
   i2c_cmd_t cmd, head;
   logic full, empty, pop, fire, nack;
   logic [7:0] rdata, rd_cur;
   logic [WD_W-1:0] wd;
   assign cmd = '{addr: cmd_addr, rw: cmd_rw, data: cmd_wdata};
   assign cmd_ready = !full;
   assign m_start = state == LAUNCH;
   assign rsp_valid = state == RESP;
   assign rd_cur = (state == WAIT_DONE && m_valid_out && m_rw) ? m_data_out : rdata;
   i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .din   (cmd),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );
   always_comb begin
      state_n = state;
      pop = 1'b0;
      fire = 1'b0;
      err_n = ERR_OK;
      unique case (state)
         IDLE: if (!empty && !m_busy) begin
            pop = 1'b1;
            state_n = LAUNCH;
         end
         LAUNCH: state_n = WAIT_BUSY;
         WAIT_BUSY: if (m_busy) state_n = WAIT_DONE;
            else if (wd <= WD_W'(1)) begin
               fire = 1'b1;
               err_n = ERR_START_TO;
            end
         WAIT_DONE: if (!m_busy) begin
               fire = 1'b1;
               err_n = (nack || m_erro_addr) ? ERR_NACK : ERR_OK;
            end else if (wd <= WD_W'(1)) begin
               fire = 1'b1;
               err_n = ERR_TXN_TO;
            end
         RESP: if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (fire) state_n = RESP;
   end
   // watchdog starts at pop so the LAUNCH cycle counts toward the start timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         m_addr <= '0;
         m_rw <= 1'b0;
         m_data_w <= '0;
         rdata <= '0;
         nack <= 1'b0;
         wd <= '0;
         rsp_rdata <= '0;
         rsp_rw <= 1'b0;
         rsp_err <= '0;
      end else begin
         state <= state_n;
         wd <= pop ? WD_W'(START_TO) : (state == WAIT_BUSY && m_busy) ? WD_W'(TXN_TO) : (wd != '0) ? wd - 1'b1 : wd;
         if (pop) begin
            m_addr <= head.addr;
            m_rw <= head.rw;
            m_data_w <= head.data;
            rdata <= '0;
            nack <= 1'b0;
         end else if (state == WAIT_DONE) begin
            rdata <= rd_cur;
            nack <= nack || m_erro_addr;
         end
         if (fire) begin
            rsp_rw <= m_rw;
            rsp_err <= err_n;
            rsp_rdata <= (err_n == ERR_OK && m_rw) ? rd_cur : 8'h00;
         end
      end
   end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed self-checking bench with a scripted I2C master
module tb_i2c_cmd_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_rw;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic m_start, m_rw;
   logic [6:0] m_addr;
   logic [7:0] m_data_w;
   logic m_busy = 1'b0, m_valid_out = 1'b0, m_erro_addr = 1'b0;
   logic [7:0] m_data_out = '0;
   logic [2:0] fifo_level;
   int checks = 0, errors = 0;
   i2c_cmd_sequencer #(.DEPTH(4), .START_TO(16), .TXN_TO(100)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_rw(rsp_rw), .rsp_err(rsp_err), .m_start(m_start), .m_addr(m_addr),
      .m_rw(m_rw), .m_data_w(m_data_w), .m_busy(m_busy), .m_valid_out(m_valid_out),
      .m_data_out(m_data_out), .m_erro_addr(m_erro_addr), .fifo_level(fifo_level)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_addr = a;
      cmd_rw = rw;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask
   task automatic wait_start();
      int n = 0;
      while (!m_start && n < 40) begin
         tick();
         n++;
      end
      check("start_seen", m_start, 1);
   endtask
   // busy falls on the last iteration; valid/nack pulse on the chosen iteration (index >= 1)
   task automatic master(input int cyc, input int vat, input logic [7:0] rd, input int nat);
      m_busy = 1'b1;
      for (int i = 0; i < cyc; i++) begin
         tick();
         m_valid_out = (i == vat);
         m_data_out = (i == vat) ? rd : 8'h00;
         m_erro_addr = (i == nat);
         m_busy = (i != cyc - 1);
      end
      tick();
      m_valid_out = 1'b0;
      m_erro_addr = 1'b0;
   endtask
   task automatic expect_rsp(input int err, input int rw, input int rd);
      int n = 0;
      while (!rsp_valid && n < 300) begin
         tick();
         n++;
      end
      check("rsp_seen", rsp_valid, 1);
      check("rsp_err", rsp_err, err);
      check("rsp_rw", rsp_rw, rw);
      check("rsp_rdata", rsp_rdata, rd);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
   initial begin
      int n;
      logic [11:0] snap;
      repeat (2) tick();
      check("rst_ready", cmd_ready, 1);
      check("rst_level", fifo_level, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_start", m_start, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_rsp_err", rsp_err, 0);
      rst = 1'b0;
      tick();
      // write with latency check
      push_cmd(7'h50, 1'b0, 8'hA5);
      check("lvl_after_push", fifo_level, 1);
      check("no_start_n1", m_start, 0);
      tick();
      check("start_n2", m_start, 1);
      check("wr_m_addr", m_addr, 7'h50);
      check("wr_m_data_w", m_data_w, 8'hA5);
      check("wr_m_rw", m_rw, 0);
      m_busy = 1'b1;
      tick();
      check("start_one_cycle", m_start, 0);
      master(9, -1, 8'h00, -1);
      expect_rsp(0, 0, 8'h00);
      // reads, one with data in the same cycle busy falls
      push_cmd(7'h50, 1'b1, 8'h00);
      wait_start();
      master(5, 4, 8'h3C, -1);
      expect_rsp(0, 1, 8'h3C);
      push_cmd(7'h33, 1'b1, 8'hFF);
      wait_start();
      master(6, 2, 8'h5A, -1);
      expect_rsp(0, 1, 8'h5A);
      // nack on a read, then the queued write still launches
      push_cmd(7'h51, 1'b1, 8'h00);
      push_cmd(7'h52, 1'b0, 8'h77);
      check("lvl_push_pop", fifo_level, 1);
      wait_start();
      check("nack_m_addr", m_addr, 7'h51);
      master(6, 3, 8'h99, 2);
      expect_rsp(1, 1, 8'h00);
      wait_start();
      check("next_m_addr", m_addr, 7'h52);
      check("next_m_data_w", m_data_w, 8'h77);
      master(4, -1, 8'h00, -1);
      expect_rsp(0, 0, 8'h00);
      // full fifo while the master is busy
      m_busy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cmd_valid = 1'b1;
         cmd_addr = 7'(32'h10 + k);
         cmd_rw = k[0];
         cmd_wdata = 8'(32'h80 + k);
         check("full_ready", cmd_ready, k < 4);
         tick();
      end
      cmd_valid = 1'b0;
      check("full_level", fifo_level, 4);
      check("full_ready_end", cmd_ready, 0);
      m_busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_start();
         check("order_m_addr", m_addr, 32'h10 + k);
         check("order_m_data_w", m_data_w, 32'h80 + k);
         master(3, 1, 8'(32'hC0 + k), -1);
         expect_rsp(0, k & 1, (k & 1) ? 32'hC0 + k : 32'h0);
      end
      n = 0;
      repeat (10) begin
         tick();
         n += int'(m_start);
      end
      check("fifth_dropped", n, 0);
      check("drained_level", fifo_level, 0);
      // launch timeout
      push_cmd(7'h60, 1'b1, 8'h00);
      wait_start();
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      check("start_to_lat", n, 16);
      // backpressure with another command queued
      push_cmd(7'h61, 1'b0, 8'h11);
      snap = {rsp_valid, rsp_err, rsp_rw, rsp_rdata};
      repeat (20) begin
         tick();
         check("hold_stable", {rsp_valid, rsp_err, rsp_rw, rsp_rdata, m_start}, {snap, 1'b0});
      end
      expect_rsp(2, 1, 8'h00);
      check("b2b_gap", m_start, 0);
      tick();
      check("b2b_start", m_start, 1);
      check("b2b_m_addr", m_addr, 7'h61);
      // transaction timeout
      m_busy = 1'b1;
      expect_rsp(3, 0, 8'h00);
      m_busy = 1'b0;
      // reset mid-transaction
      push_cmd(7'h70, 1'b0, 8'h42);
      push_cmd(7'h71, 1'b0, 8'h43);
      wait_start();
      m_busy = 1'b1;
      repeat (3) tick();
      check("pre_rst_level", fifo_level, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_start", m_start, 0);
      check("mid_rst_m_addr", m_addr, 0);
      check("mid_rst_m_data_w", m_data_w, 0);
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_err", rsp_err, 0);
      rst = 1'b0;
      repeat (5) tick();
      m_busy = 1'b0;
      n = 0;
      repeat (20) begin
         tick();
         n += int'(rsp_valid) + int'(m_start);
      end
      check("post_rst_quiet", n, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
